dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the memory stage: req/done handshake, programmable
// wait states, combinational stall and a debug read port.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  // state | meaning
  // IDLE  | ready, accepts a request on the next edge
  // WAIT  | counting down wait states for the latched access
  // RESP  | access committed, done pulses for this one cycle

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, commit;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == IDLE);
    done     = (state == RESP);
    stall    = req & ~done;
    dbg_data = mem[dbg_addr];
  end

  // With zero wait states the commit lands on the accept edge, so use the live inputs.
  assign accept    = (state == IDLE) && req;
  assign commit    = rst && (state != RESP) && (state_nxt == RESP);
  assign we_sel    = (state == IDLE) ? we    : we_q;
  assign addr_sel  = (state == IDLE) ? addr  : addr_q;
  assign wdata_sel = (state == IDLE) ? wdata : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit && !we_sel) rdata <= mem[addr_sel];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && we_sel) mem[addr_sel] <= wdata_sel;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a W=2 and a W=0 instance checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       req [2];
  logic       we [2];
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic [7:0] dbg_addr [2];
  logic       ready [2];
  logic       done [2];
  logic       stall [2];
  logic [7:0] rdata [2];
  logic [7:0] dbg_data [2];

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .stall(stall[0]),
    .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]));

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .stall(stall[1]),
    .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]));

  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Model: an access accepted at edge n completes (commits, done high) at edge n+W,
  // and the responder is free again from edge n+W+1.
  int         cyc = 0;
  bit         busy [2];
  int         done_edge [2];
  bit         m_done [2];
  logic [7:0] m_rdata [2];
  bit         m_rk [2];
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  bit         t_we [2];
  logic [7:0] t_addr [2];
  logic [7:0] t_wdata [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        busy[d] = 0; m_done[d] = 0; m_rdata[d] = 8'h00; m_rk[d] = 1;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) begin
          if (cyc == done_edge[d] + 1) begin
            busy[d] = 0; m_done[d] = 0;
          end
        end else if (req[d]) begin
          busy[d] = 1; done_edge[d] = cyc + wc(d);
          t_we[d] = we[d]; t_addr[d] = addr[d]; t_wdata[d] = wdata[d];
        end
        if (busy[d] && cyc == done_edge[d]) begin
          if (t_we[d]) begin
            m_mem[d][t_addr[d]] = t_wdata[d]; m_known[d][t_addr[d]] = 1;
          end else begin
            m_rdata[d] = m_mem[d][t_addr[d]]; m_rk[d] = m_known[d][t_addr[d]];
          end
          m_done[d] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      chk("ready", d, 32'(ready[d]), 32'(!busy[d]));
      chk("done", d, 32'(done[d]), 32'(m_done[d]));
      chk("stall", d, 32'(stall[d]), 32'(req[d] & ~m_done[d]));
      if (m_rk[d]) chk("rdata", d, 32'(rdata[d]), 32'(m_rdata[d]));
      if (m_known[d][dbg_addr[d]]) chk("dbg_data", d, 32'(dbg_data[d]), 32'(m_mem[d][dbg_addr[d]]));
    end
  end

  // One access: returns cycles from req rise to done, stall-high cycles, ready-low cycles.
  task automatic access(input int d, input bit w, input logic [7:0] a, input logic [7:0] dv,
                        output int lat, output int stl, output int rlow, output logic [7:0] rd);
    bit seen;
    seen = 0; lat = 0; stl = 0; rlow = 0; rd = 8'h00;
    @(posedge clk); #2;
    req[d] = 1; we[d] = w; addr[d] = a; wdata[d] = dv;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ready[d]) rlow++;
      if (done[d]) begin
        seen = 1; lat = i; rd = rdata[d];
        break;
      end
      if (stall[d]) stl++;
    end
    chk("done_seen", d, 32'(seen), 32'd1);
    @(posedge clk); #2;
    req[d] = 0;
  endtask

  int         lat, stl, rlow;
  logic [7:0] rd;
  int         last_done;
  bit         seen;
  bit         seq_we [6] = '{1, 0, 1, 0, 1, 0};
  logic [7:0] seq_a [6] = '{8'h30, 8'h30, 8'h31, 8'h31, 8'h30, 8'h30};
  logic [7:0] seq_d [6] = '{8'hC1, 8'h00, 8'hD2, 8'h00, 8'hE3, 8'h00};
  logic [7:0] seq_r [6] = '{8'h00, 8'hC1, 8'h00, 8'hD2, 8'h00, 8'hE3};

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 8'h00; wdata[d] = 8'h00; dbg_addr[d] = 8'h00;
    end

    // Power-up reset held 3 cycles; stall follows req
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      req[0] = (i == 1);
      @(negedge clk);
      chk("pu_ready", 0, 32'(ready[0]), 32'd1);
      chk("pu_done", 0, 32'(done[0]), 32'd0);
      chk("pu_rdata", 0, 32'(rdata[0]), 32'h00);
      chk("pu_stall", 0, 32'(stall[0]), (i == 1) ? 32'd1 : 32'd0);
    end
    req[0] = 0;
    @(posedge clk); #2;
    rst = 1;

    // W=2 store then load
    access(0, 1, 8'h10, 8'hA5, lat, stl, rlow, rd);
    chk("st_lat", 0, 32'(lat), 32'd3);
    chk("st_stall", 0, 32'(stl), 32'd3);
    access(0, 0, 8'h10, 8'h00, lat, stl, rlow, rd);
    chk("ld_lat", 0, 32'(lat), 32'd3);
    chk("ld_stall", 0, 32'(stl), 32'd3);
    chk("ld_rdata", 0, 32'(rd), 32'hA5);
    dbg_addr[0] = 8'h10;
    @(negedge clk);
    chk("dbg_10", 0, 32'(dbg_data[0]), 32'hA5);

    // W=0 store then load at top address
    access(1, 1, 8'hFF, 8'h3C, lat, stl, rlow, rd);
    access(1, 0, 8'hFF, 8'h00, lat, stl, rlow, rd);
    chk("w0_lat", 1, 32'(lat), 32'd1);
    chk("w0_rdata", 1, 32'(rd), 32'h3C);
    chk("w0_ready_low", 1, 32'(rlow), 32'd1);
    chk("w0_stall", 1, 32'(stl), 32'd1);

    // Reset during WAIT aborts the store
    access(0, 1, 8'h20, 8'h11, lat, stl, rlow, rd);
    @(posedge clk); #2;
    req[0] = 1; we[0] = 1; addr[0] = 8'h20; wdata[0] = 8'h77;
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", 0, 32'(ready[0]), 32'd1);
    chk("rst_done", 0, 32'(done[0]), 32'd0);
    chk("rst_rdata", 0, 32'(rdata[0]), 32'h00);
    req[0] = 0;
    dbg_addr[0] = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", 0, 32'(done[0]), 32'd0);
    end
    chk("rst_dbg_20", 0, 32'(dbg_data[0]), 32'h11);
    @(posedge clk); #2;
    rst = 1;

    // req held high, alternating store/load: one done every 4 cycles
    @(posedge clk); #2;
    req[0] = 1; we[0] = seq_we[0]; addr[0] = seq_a[0]; wdata[0] = seq_d[0];
    last_done = 0;
    for (int k = 0; k < 6; k++) begin
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done[0]) begin
          seen = 1;
          break;
        end
      end
      chk("b2b_done_seen", 0, 32'(seen), 32'd1);
      if (k > 0) chk("b2b_period", 0, 32'(ncyc - last_done), 32'd4);
      if (!seq_we[k]) chk("b2b_rdata", 0, 32'(rdata[0]), 32'(seq_r[k]));
      last_done = ncyc;
      @(posedge clk); #2;
      if (k < 5) begin
        we[0] = seq_we[k+1]; addr[0] = seq_a[k+1]; wdata[0] = seq_d[k+1];
      end else begin
        req[0] = 0;
      end
    end

    // Inputs changed and req dropped during WAIT of a load
    access(0, 1, 8'h05, 8'h5A, lat, stl, rlow, rd);
    access(0, 1, 8'h06, 8'h66, lat, stl, rlow, rd);
    @(posedge clk); #2;
    req[0] = 1; we[0] = 0; addr[0] = 8'h05;
    @(posedge clk); #2;
    req[0] = 0; we[0] = 1; addr[0] = 8'h06; wdata[0] = 8'hFF;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done[0]) begin
        seen = 1;
        break;
      end
    end
    chk("drop_done_seen", 0, 32'(seen), 32'd1);
    chk("drop_rdata", 0, 32'(rdata[0]), 32'h5A);
    dbg_addr[0] = 8'h06;
    @(negedge clk);
    chk("drop_dbg_06", 0, 32'(dbg_data[0]), 32'h66);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
